// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shifter: op codes, FSM states, shamt width helper.
// The rotate op codes are recognised only when SHIFT_ROTATE_EN is defined.
package shift_pkg;

  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROL = 4'b1100;
  localparam logic [3:0] OP_ROR = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int shamt_w(input int xlen);
    return $clog2(xlen);
  endfunction

  function automatic logic op_known(input logic [3:0] op);
    case (op)
      OP_SLL, OP_SRL, OP_SRA: return 1'b1;
`ifdef SHIFT_ROTATE_EN
      OP_ROL, OP_ROR:         return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift pass; the caller keeps amt_i within the per-cycle step limit.
// Rotates are compiled in only with SHIFT_ROTATE_EN.
module shift_step
  import shift_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]              op_i,
  input  logic [XLEN-1:0]         din_i,
  input  logic [$clog2(XLEN)-1:0] amt_i,
  output logic [XLEN-1:0]         dout_o
);

  always_comb begin
    dout_o = '0;
    case (op_i)
      OP_SLL: dout_o = din_i << amt_i;
      OP_SRL: dout_o = din_i >> amt_i;
      OP_SRA: dout_o = $unsigned($signed(din_i) >>> amt_i);
`ifdef SHIFT_ROTATE_EN
      // amt_i is never 0 here, so the complementary shift stays below XLEN
      OP_ROL: dout_o = (din_i << amt_i) | (din_i >> (XLEN - int'(amt_i)));
      OP_ROR: dout_o = (din_i >> amt_i) | (din_i << (XLEN - int'(amt_i)));
`endif
      default: dout_o = '0;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Iterative shifter: up to STEP bit positions per cycle, valid/ready on both sides.
// Optional ROL/ROR ops are enabled by SHIFT_ROTATE_EN.
module shift_unit
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHW = shamt_w(XLEN);
  localparam logic [SHW-1:0] STEP_A = SHW'(STEP);

  state_e          state_q;
  logic [XLEN-1:0] data_q, data_d;
  logic [SHW-1:0]  rem_q, amt;
  logic [3:0]      op_q;
  logic            in_ready_q, out_valid_q, zero_q;
  logic [SHW-1:0]  shamt;
  logic            unused_hi;

  assign shamt     = operand2[SHW-1:0];
  assign unused_hi = ^operand2[XLEN-1:SHW];
  assign amt       = (rem_q > STEP_A) ? STEP_A : rem_q;

  shift_step #(.XLEN(XLEN)) u_step (
    .op_i  (op_q),
    .din_i (data_q),
    .amt_i (amt),
    .dout_o(data_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      rem_q       <= '0;
      op_q        <= OP_SLL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q       <= alu_control;
          in_ready_q <= 1'b0;
          if (!op_known(alu_control)) begin
            // unknown ops finish immediately with a zero result
            data_q      <= '0;
            rem_q       <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (shamt == '0) begin
            data_q      <= operand1;
            rem_q       <= '0;
            zero_q      <= (operand1 == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            data_q  <= operand1;
            rem_q   <= shamt;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          data_q <= data_d;
          rem_q  <= rem_q - amt;
          if (rem_q == amt) begin
            zero_q      <= (data_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = data_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit (XLEN=32, STEP=4); rotate expectations follow SHIFT_ROTATE_EN.
module tb_shift_unit;
  import shift_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
    int          acc;
    int          hold;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [3:0]  alu_control;
  logic [31:0] operand1, operand2, result;

  int   cyc = 0;
  int   cmp = 0;
  int   err = 0;
  exp_t q[$];

  shift_unit #(.XLEN(32), .STEP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .operand1   (operand1),
    .operand2   (operand2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Called at a negedge; waits for in_ready, presents the request, then scribbles the inputs.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input int hold);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    alu_control = op;
    operand1    = a;
    operand2    = b;
    in_valid    = 1'b1;
    e.res  = res;
    e.z    = (res == 32'd0);
    e.lat  = lat;
    e.acc  = cyc + 1;
    e.hold = hold;
    q.push_back(e);
    @(negedge clk);
    // after accept these must not matter, and in_valid stays high through BUSY/DONE
    operand1    = ~a;
    operand2    = b + 32'd3;
    alu_control = op ^ 4'b0001;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  // Monitor: pops on the first cycle out_valid is seen, then checks hold stability.
  initial begin
    logic        seen = 1'b0;
    logic [31:0] cap = '0;
    int          hold = 0;
    exp_t        e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
        out_ready = 1'b0;
        continue;
      end
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("zero", 32'(zero), 32'(e.z));
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          cap  = result;
          hold = e.hold;
        end
      end else if (out_valid && seen) begin
        chk("result_stable", result, cap);
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
      end
      if (out_valid) begin
        if (hold == 0) out_ready = 1'b1;
        else begin
          hold--;
          out_ready = 1'b0;
        end
      end else begin
        seen = 1'b0;
        out_ready = cyc[0];  // toggling outside DONE must be harmless
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    alu_control = 4'd0;
    operand1 = '0;
    operand2 = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // -20 << 10 = -20480
    issue(OP_SLL, 32'hffffffec, 32'd10, 32'hffffb000, 4, 0);
    issue(OP_SRA, 32'h80000000, 32'd31, 32'hffffffff, 9, 0);
    issue(OP_SRL, 32'h80000000, 32'd31, 32'h00000001, 9, 0);
    issue(OP_SLL, 32'h12345678, 32'h00000020, 32'h12345678, 1, 2);
    issue(OP_SRL, 32'hf0f0f0f0, 32'd4, 32'h0f0f0f0f, 2, 5);
    issue(OP_SLL, 32'h00000001, 32'd31, 32'h80000000, 9, 0);
    issue(OP_SRL, 32'h00000100, 32'd5, 32'h00000008, 3, 1);
    issue(OP_SLL, 32'h80000000, 32'd1, 32'h00000000, 2, 0);
    issue(4'b0000, 32'hdeadbeef, 32'd5, 32'h00000000, 1, 0);
    issue(OP_SRA, 32'h7ffffff0, 32'hffffffe4, 32'h07ffffff, 2, 0);
`ifdef SHIFT_ROTATE_EN
    issue(OP_ROR, 32'h0000000f, 32'd4, 32'hf0000000, 2, 0);
    issue(OP_ROL, 32'h80000001, 32'd1, 32'h00000003, 2, 0);
`else
    issue(OP_ROR, 32'h0000000f, 32'd4, 32'h00000000, 1, 0);
    issue(OP_ROL, 32'h80000001, 32'd1, 32'h00000000, 1, 0);
`endif
    in_valid = 1'b0;
    drain();

    // reset in the middle of a SLL by 20: nothing may come out
    @(negedge clk);
    alu_control = OP_SLL;
    operand1 = 32'h00000003;
    operand2 = 32'd20;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", 32'(zero), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    issue(OP_SLL, 32'h00000003, 32'd20, 32'h00300000, 6, 0);
    in_valid = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
